// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   uart_tx_state_e : transmitter FSM states
//   OVERSAMPLE      : baud ticks per data/start bit
//   tick_cnt_width  : width of the per-bit tick counter for a given stop length
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  // Five bits cover the 16-tick bit period and the usual 1/1.5 stop lengths.
  // Longer stop lengths get enough bits to hold SB_TICK-1 with room to spare.
  function automatic int tick_cnt_width(input int sb_tick);
    return (sb_tick > 31) ? $clog2(sb_tick + 1) : 5;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Oversampling baud tick generator.
//   clk    : system clock
//   arst_n : asynchronous active-low reset
//   clr    : synchronous clear of the divisor counter (frame start)
//   dvsr   : divisor; the counter runs 0..dvsr, so ticks come every dvsr+1 clocks
//   tick   : high in the cycle the counter equals dvsr
module baud_gen #(
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  clr,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  output logic                  tick
);

  logic [DVSR_WIDTH-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == dvsr)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // dvsr = 0 keeps the counter at zero, which yields a tick every clock.
  assign tick = (cnt == dvsr);

endmodule

// File: rtl/uart_tx_fwft.sv
// UART 8N1-style transmitter that drains a first-word-fall-through FIFO.
// Pops one word whenever the FIFO is non-empty and the line is idle, then
// sends start bit, DATA_BITS payload bits (LSB first) and SB_TICK ticks of stop.
//   clk        : system clock
//   arst_n     : asynchronous active-low reset (aborts a frame in flight)
//   dvsr       : baud divisor, captured at frame start; tick period dvsr+1 clocks
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO head word, valid while fifo_empty is low
//   fifo_rd    : one-cycle pop strobe, asserted combinationally in IDLE
//   tx         : registered serial line, idles high
//   tx_busy    : high from the edge after a pop until the stop bit ends
module uart_tx_fwft
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  fifo_empty,
  input  logic [DATA_BITS-1:0]  fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int TW = tick_cnt_width(SB_TICK);
  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] IDX_LAST  = NW'(DATA_BITS - 1);

  uart_tx_state_e        state, state_next;
  logic [TW-1:0]         s_cnt, s_next;
  logic [NW-1:0]         n_cnt, n_next;
  logic [DATA_BITS-1:0]  shreg, shreg_next;
  logic [DVSR_WIDTH-1:0] dvsr_q, dvsr_next;
  logic                  tx_q, tx_next;
  logic                  tick;
  logic                  pop;

  // NOTE: the FSM state is already IDLE while reset is held, so the pop
  // strobe is qualified with arst_n; otherwise a non-empty FIFO would be
  // drained during reset while none of the words are captured.
  assign pop     = arst_n && (state == IDLE) && !fifo_empty;
  assign fifo_rd = pop;

  baud_gen #(
    .DVSR_WIDTH(DVSR_WIDTH)
  ) u_baud_gen (
    .clk   (clk),
    .arst_n(arst_n),
    .clr   (pop),
    .dvsr  (dvsr_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n_cnt  <= '0;
      shreg  <= '0;
      dvsr_q <= '0;
      tx_q   <= 1'b1;
    end else begin
      state  <= state_next;
      s_cnt  <= s_next;
      n_cnt  <= n_next;
      shreg  <= shreg_next;
      dvsr_q <= dvsr_next;
      tx_q   <= tx_next;
    end
  end

  // NOTE: every variable gets its hold value before the case statement, so
  // no path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    s_next     = s_cnt;
    n_next     = n_cnt;
    shreg_next = shreg;
    dvsr_next  = dvsr_q;

    unique case (state)
      IDLE: begin
        if (pop) begin
          shreg_next = fifo_data;
          dvsr_next  = dvsr;
          s_next     = '0;
          n_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt == BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt == BIT_LAST) begin
            s_next     = '0;
            shreg_next = shreg >> 1;
            if (n_cnt == IDX_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n_cnt + 1'b1;
            end
          end else begin
            s_next = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt == STOP_LAST) begin
            s_next     = '0;
            state_next = IDLE;
          end else begin
            s_next = s_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is derived from the next state so tx changes on the same
  // edge as the state: it falls on the pop edge and follows each bit boundary.
  always_comb begin
    tx_next = 1'b1;
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fwft.sv
// Self-checking bench for uart_tx_fwft: a behavioural FIFO feeds the DUT,
// every pop pushes the expected frame into a scoreboard, and a monitor
// reconstructs each frame from tx and compares it level by level.
module tb_uart_tx_fwft;

  localparam int DW = 11;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [DW-1:0] dvsr;
  logic          fifo_empty;
  logic [7:0]    fifo_data;
  logic          fifo_rd, tx, tx_busy;

  // second instance with a two-stop-bit frame
  logic [DW-1:0] dvsr2;
  logic          empty2;
  logic [7:0]    data2;
  logic          rd2, tx2, busy2;

  always #5 clk = ~clk;

  uart_tx_fwft #(.DATA_BITS(8), .SB_TICK(16), .DVSR_WIDTH(DW)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .dvsr      (dvsr),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  uart_tx_fwft #(.DATA_BITS(8), .SB_TICK(32), .DVSR_WIDTH(DW)) dut32 (
    .clk       (clk),
    .arst_n    (arst_n),
    .dvsr      (dvsr2),
    .fifo_empty(empty2),
    .fifo_data (data2),
    .fifo_rd   (rd2),
    .tx        (tx2),
    .tx_busy   (busy2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         dv;
    longint     pop_cyc;
  } exp_t;

  logic [7:0] fq[$];      // words waiting in the modelled FIFO
  exp_t       sb[$];      // frames popped but not yet observed
  longint     starts[$];  // cycle of first start-bit sample per frame
  longint     cyc = 0;
  int         pops = 0;
  int         rd_viol = 0;
  int         aborted = 0;
  bit         mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level of bit slot k: start, 8 data bits LSB first, stop.
  function automatic int level(input logic [7:0] w, input int k);
    if (k == 0) return 0;
    if (k <= 8) return int'(w[k-1]);
    return 1;
  endfunction

  // FWFT FIFO model: outputs change only at negedge; a pop seen in the cycle
  // is consumed from the model, the DUT captures the head on the next posedge.
  initial begin : fifo_model
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    forever begin
      @(negedge clk);
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
      #1;
      if (fifo_rd) begin
        if (fifo_empty || tx_busy) begin
          rd_viol++;
        end else begin
          sb.push_back('{fq[0], int'(dvsr), cyc});
          void'(fq.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin : monitor
    exp_t   e;
    longint st;
    bit     ab, stable, busy_ok;
    int     first, len;
    forever begin
      @(negedge clk);
      if (arst_n && tx === 1'b0) begin
        mon_busy = 1'b1;
        st = cyc;
        starts.push_back(st);
        if (sb.size() == 0) begin
          check("unexpected frame", sb.size(), 1);
          while (tx !== 1'b1) @(negedge clk);
        end else begin
          e = sb.pop_front();
          check($sformatf("frame %02h pop-to-start", e.data), st - e.pop_cyc, 1);
          ab = 1'b0;
          busy_ok = 1'b1;
          for (int k = 0; k < 10; k++) begin
            len = 16 * (e.dv + 1);
            stable = 1'b1;
            first = 0;
            for (int j = 0; j < len; j++) begin
              if (!(k == 0 && j == 0)) @(negedge clk);
              if (!arst_n) begin
                ab = 1'b1;
                break;
              end
              if (j == 0) first = int'(tx);
              else if (int'(tx) != first) stable = 1'b0;
              if (tx_busy !== 1'b1) busy_ok = 1'b0;
            end
            if (ab) break;
            check($sformatf("frame %02h slot %0d level", e.data, k),
                  stable ? first : 2, level(e.data, k));
          end
          if (ab) begin
            aborted++;
          end else begin
            check($sformatf("frame %02h busy during frame", e.data), busy_ok, 1);
            @(negedge clk);
            check($sformatf("frame %02h busy,tx after stop", e.data),
                  {tx_busy, tx}, 2'b01);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int stable_cnt;
    int n;
    stable_cnt = 0;
    n = 0;
    while (stable_cnt < 3 && n < budget) begin
      step();
      n++;
      if (fq.size() == 0 && !tx_busy && !mon_busy && fifo_empty) stable_cnt++;
      else stable_cnt = 0;
    end
    check("idle reached within budget", stable_cnt >= 3, 1);
  endtask

  task automatic measure_busy(output int n);
    int w;
    w = 0;
    n = 0;
    while (!tx_busy && w < 5000) begin
      step();
      w++;
    end
    while (tx_busy && n < 100000) begin
      n++;
      step();
    end
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int     n, viol, p0, a0, first, busy_cnt;
    bit     stable;
    longint d;

    arst_n = 1'b0;
    dvsr   = '0;
    dvsr2  = '0;
    empty2 = 1'b1;
    data2  = 8'h00;
    repeat (3) step();
    check("reset tx", tx, 1);
    check("reset tx_busy", tx_busy, 0);
    check("reset fifo_rd", fifo_rd, 0);

    // Word queued during reset must not be popped until release.
    fq.push_back(8'hA5);
    repeat (3) step();
    check("fifo_rd held low in reset", fifo_rd, 0);
    check("tx held high in reset", tx, 1);
    check("no pops during reset", pops, 0);

    // 1) 0xA5, dvsr=0
    arst_n = 1'b1;
    measure_busy(n);
    check("A5 busy length", n, 160);
    wait_idle(2000);
    check("A5 pop count", pops, 1);

    // 2) 0x00 then 0xFF, dvsr=3, back to back
    dvsr = 11'd3;
    p0 = pops;
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    wait_idle(5000);
    check("two-word pop count", pops - p0, 2);
    d = starts[starts.size()-1] - starts[starts.size()-2];
    check("back-to-back start spacing", d, 641);

    // 3) FIFO empty for 1000 cycles
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0 || tx !== 1'b1) viol++;
    end
    check("idle violations over 1000 cycles", viol, 0);

    // 4) dvsr 1 -> 7 in the middle of frame 0x3C
    dvsr = 11'd1;
    fq.push_back(8'h3C);
    fq.push_back(8'h99);
    n = 0;
    while (!tx_busy && n < 1000) begin
      step();
      n++;
    end
    repeat (100) step();
    dvsr = 11'd7;
    wait_idle(10000);
    d = starts[starts.size()-1] - starts[starts.size()-2];
    check("3C frame spacing with dvsr=1", d, 321);

    // 5) reset during DATA of 0x81
    dvsr = 11'd0;
    a0 = aborted;
    fq.push_back(8'h81);
    fq.push_back(8'h42);
    n = 0;
    while (!tx_busy && n < 1000) begin
      step();
      n++;
    end
    repeat (60) step();
    arst_n = 1'b0;
    #1;
    check("abort tx", tx, 1);
    check("abort tx_busy", tx_busy, 0);
    repeat (3) step();
    check("fifo_rd low in mid-frame reset", fifo_rd, 0);
    arst_n = 1'b1;
    wait_idle(2000);
    check("aborted frames", aborted - a0, 1);

    // randomized words, divisors and gaps
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 300)) step();
      dvsr = DW'($urandom_range(0, 2));
      fq.push_back(8'($urandom));
    end
    wait_idle(40000);

    // 6) SB_TICK=32 instance, 0x55, dvsr=0
    data2  = 8'h55;
    empty2 = 1'b0;
    @(negedge clk);
    check("sb32 fifo_rd", rd2, 1);
    @(posedge clk);
    #1;
    empty2 = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      stable = 1'b1;
      first = 0;
      for (int j = 0; j < ((k < 9) ? 16 : 32); j++) begin
        @(negedge clk);
        if (j == 0) first = int'(tx2);
        else if (int'(tx2) != first) stable = 1'b0;
        if (busy2) busy_cnt++;
      end
      check($sformatf("sb32 slot %0d level", k), stable ? first : 2, level(8'h55, k));
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (busy2) busy_cnt++;
      if (tx2 !== 1'b1 || rd2 !== 1'b0) viol++;
    end
    check("sb32 frame length", busy_cnt, 176);
    check("sb32 line idle after frame", viol, 0);

    check("fifo_rd outside idle or when empty", rd_viol, 0);
    check("scoreboard drained", sb.size(), 0);
    check("model fifo drained", fq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
